booth_seq_multiplier: RTL and testbench

Sequential signed multiplier using radix-2 Booth recoding, one recode/add/arithmetic-right-shift step per clock. It sits downstream of the operand-shifting datapath in the lab pipeline. It consumes two signed operands through a valid/ready handshake and returns the full-width signed product through a second valid/ready handshake. Each step's arithmetic right shift of the {A, Q, q_m1} chain carries the sign bit, matching the arithmetic mode of the shift stage.

---
 rtl/booth_seq_multiplier_pkg.sv | 15 +
 rtl/booth_seq_multiplier_booth_step.sv | 34 +++
 rtl/booth_seq_multiplier.sv | 104 ++++++++++
 tb/tb_booth_seq_multiplier.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_seq_multiplier_pkg.sv
// Shared state encoding and Booth recode constants for the sequential multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Indexed by {Q[0], q_m1}; 2'b11 behaves like NOP.
    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_seq_multiplier_booth_step.sv
// One radix-2 Booth step: recode {Q[0], q_m1}, add/sub Mx into A, then
// arithmetic right shift of the {A, Q, q_m1} chain.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             qm1_i,
    input  logic [WIDTH:0]   mx_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             qm1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = a_i;
        case ({q_i[0], qm1_i})
            BOOTH_NOP: sum = a_i;
            BOOTH_ADD: sum = a_i + mx_i;
            BOOTH_SUB: sum = a_i - mx_i;
            default:   sum = a_i;
        endcase
    end

    // A carries one guard bit, so sum[WIDTH] is always the true sign.
    assign a_o   = {sum[WIDTH], sum[WIDTH:1]};
    assign q_o   = {sum[0], q_i[WIDTH-1:1]};
    assign qm1_o = q_i[0];

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential signed Booth multiplier: one step per clock, valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | WIDTH Booth steps in progress, busy high
//   DONE  | product held, out_valid high until out_ready
module booth_seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    mult_state_t        state_q, state_d;
    logic [WIDTH:0]     a_q, a_d, a_step;
    logic [WIDTH-1:0]   q_q, q_d, q_step;
    logic               qm1_q, qm1_d, qm1_step;
    logic [WIDTH:0]     mx_q, mx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_i   (a_q),
        .q_i   (q_q),
        .qm1_i (qm1_q),
        .mx_i  (mx_q),
        .a_o   (a_step),
        .q_o   (q_step),
        .qm1_o (qm1_step)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        mx_d      = mx_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = '0;
                    q_d     = multiplier;
                    qm1_d   = 1'b0;
                    mx_d    = {multiplicand[WIDTH-1], multiplicand};
                    cnt_d   = CW'(WIDTH);
                end
            end
            RUN: begin
                a_d   = a_step;
                q_d   = q_step;
                qm1_d = qm1_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d   = DONE;
                    product_d = {a_step[WIDTH-1:0], q_step};
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            mx_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            mx_q      <= mx_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign product   = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier: expected products are queued at
// acceptance and popped by an independent output monitor.
module tb_booth_seq_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] product;
    logic           busy;

    int tests = 0;
    int fails = 0;
    int n_sent = 0;
    int n_out = 0;
    int busy_cnt = 0;
    bit rand_or = 1'b0;
    logic [2*W-1:0] sb[$];

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
        int p;
        p = int'($signed(m)) * int'($signed(q));
        return p[2*W-1:0];
    endfunction

    // Output monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_product", 32'(product), 32'hDEAD_BEEF);
                end else begin
                    chk("product", 32'(product), 32'(sb.pop_front()));
                end
                chk("busy_cycles", 32'(busy_cnt), 32'(W));
                busy_cnt = 0;
                n_out++;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_or) begin
            #1;
            if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic [2*W-1:0] exp, output int waits);
        multiplicand = m;
        multiplier   = q;
        in_valid     = 1'b1;
        waits        = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(exp);
        n_sent++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [W-1:0] m; logic [W-1:0] q; logic [2*W-1:0] p; } vec_t;
    vec_t dirv[$];

    initial begin
        int waits;
        int lat;
        logic [2*W-1:0] held;
        logic [W-1:0] rm, rq;

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic case with latency measured from the accepting edge.
        send(8'd3, 8'd5, 16'h000F, waits);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk("latency", 32'(lat), 32'(W));
        wait_drain();

        dirv.push_back('{8'hFD, 8'd5,  16'hFFF1});
        dirv.push_back('{8'd5,  8'hFD, 16'hFFF1});
        dirv.push_back('{8'hF9, 8'hFA, 16'h002A});
        dirv.push_back('{8'h80, 8'h80, 16'h4000});
        dirv.push_back('{8'h80, 8'h7F, 16'hC080});
        dirv.push_back('{8'h7F, 8'h7F, 16'h3F01});
        dirv.push_back('{8'h00, 8'h55, 16'h0000});
        foreach (dirv[i]) begin
            send(dirv[i].m, dirv[i].q, dirv[i].p, waits);
            wait_drain();
        end

        // Backpressure: product must hold and new operands must be refused.
        out_ready = 1'b0;
        send(8'd10, 8'hFC, 16'hFFD8, waits);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
        end
        held = product;
        chk("bp_held_value", 32'(held), 32'hFFD8);
        multiplicand = 8'd2;
        multiplier   = 8'd2;
        in_valid     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_product", 32'(product), 32'(held));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(8'd2, 8'd2, 16'h0004, waits);
        chk("bp_accept_delay", 32'(waits), 32'd1);
        wait_drain();

        // Asynchronous reset during RUN aborts the operation.
        send(8'd5, 8'd7, 16'h0023, waits);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        void'(sb.pop_back());
        n_sent--;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'd2, 8'd3, 16'h0006, waits);
        wait_drain();

        // Randomized operands with random input gaps and output backpressure.
        rand_or = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rm = W'($urandom);
            rq = W'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(rm, rq, ref_mul(rm, rq), waits);
        end
        wait_drain();
        rand_or = 1'b0;
        #2 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        chk("products_out_vs_sent", 32'(n_out), 32'(n_sent));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
